// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: one instance per requester (core, loader).
// master = requester side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (output req, we, adr, wdata, input rdata, ready);
  modport slave  (input req, we, adr, wdata, output rdata, ready);
endinterface

// File: rtl/arb_wait_cnt.sv
// Loadable down-counter timing the memory access window; saturates at zero.
module arb_wait_cnt
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (core / loader) arbiter in front of a single shared memory port.
// Each transfer: IDLE (arbitrate) -> ACCESS for WAIT_CYCLES cycles -> DONE (ready pulse).
// Optional macro ARB_FAIR_EN: round-robin between core and loader on contention;
// without it the core always wins contention.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  core,
  mem_arbiter_if.slave  load,
  output logic [AW-1:0] Adr,
  output logic [DW-1:0] WriteData,
  output logic          MemWrite,
  output logic          MemEn,
  input  logic [DW-1:0] ReadData
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  logic             winner;
  logic             lat_we;
  logic             any_req;
  logic             pick;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  assign any_req = core.req | load.req;

`ifdef ARB_FAIR_EN
  logic rr_ptr;
  // Round-robin: the pointer's requester wins contention; a lone requester always wins.
  assign pick = (core.req && (!load.req || (rr_ptr == REQ_CORE))) ? REQ_CORE : REQ_LOAD;
`else
  // Fixed priority: core wins whenever it is requesting.
  assign pick = core.req ? REQ_CORE : REQ_LOAD;
`endif

  assign cnt_load = (state == IDLE) && any_req;
  assign cnt_dec  = (state == ACCESS);

  arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_INIT),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Transfer sequencer; memory-side and requester-side outputs are all registered.
  // MemWrite is set one edge ahead so it is high exactly in the cycle where the count reaches zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      winner      <= REQ_CORE;
      lat_we      <= 1'b0;
      Adr         <= '0;
      WriteData   <= '0;
      MemEn       <= 1'b0;
      MemWrite    <= 1'b0;
      core.rdata  <= '0;
      core.ready  <= 1'b0;
      load.rdata  <= '0;
      load.ready  <= 1'b0;
`ifdef ARB_FAIR_EN
      rr_ptr      <= REQ_CORE;
`endif
    end else begin
      core.ready <= 1'b0;
      load.ready <= 1'b0;
      MemWrite   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            winner    <= pick;
            lat_we    <= (pick == REQ_LOAD) ? load.we    : core.we;
            Adr       <= (pick == REQ_LOAD) ? load.adr   : core.adr;
            WriteData <= (pick == REQ_LOAD) ? load.wdata : core.wdata;
            MemWrite  <= ((pick == REQ_LOAD) ? load.we : core.we) && (WAIT_CYCLES == 1);
            MemEn     <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            MemEn     <= 1'b0;
            Adr       <= '0;
            WriteData <= '0;
            if (winner == REQ_CORE) begin
              if (!lat_we) core.rdata <= ReadData;
              core.ready <= 1'b1;
            end else begin
              if (!lat_we) load.rdata <= ReadData;
              load.ready <= 1'b1;
            end
            state <= DONE;
          end else begin
            MemWrite <= lat_we && (cnt == CNT_W'(1));
          end
        end
        DONE: begin
`ifdef ARB_FAIR_EN
          rr_ptr <= ~winner;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a WAIT_CYCLES=1 and a WAIT_CYCLES=3 arbiter share clock and reset.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) c1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) l1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) c3 ();
  mem_arbiter_if #(.AW(32), .DW(32)) l3 ();

  logic [31:0] adr1, wd1, rd1, adr3, wd3, rd3;
  logic        mw1, me1, mw3, me3;

  mem_arbiter #(.WAIT_CYCLES(1), .AW(32), .DW(32)) dut1 (
    .clk(clk), .reset(reset), .core(c1), .load(l1),
    .Adr(adr1), .WriteData(wd1), .MemWrite(mw1), .MemEn(me1), .ReadData(rd1)
  );

  mem_arbiter #(.WAIT_CYCLES(3), .AW(32), .DW(32)) dut3 (
    .clk(clk), .reset(reset), .core(c3), .load(l3),
    .Adr(adr3), .WriteData(wd3), .MemWrite(mw3), .MemEn(me3), .ReadData(rd3)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_memen1(output logic found);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (me1 === 1'b1) found = 1'b1;
    end
  endtask

  logic [31:0] exp_grant [4];
  logic        found;
  logic        seen_mw, seen_rdy;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    c1.req = 0; c1.we = 0; c1.adr = 0; c1.wdata = 0;
    l1.req = 0; l1.we = 0; l1.adr = 0; l1.wdata = 0;
    c3.req = 0; c3.we = 0; c3.adr = 0; c3.wdata = 0;
    l3.req = 0; l3.we = 0; l3.adr = 0; l3.wdata = 0;
    rd1 = 32'hDEAD_BEEF;
    rd3 = 32'h0;
`ifdef ARB_FAIR_EN
    exp_grant[0] = 32'd1; exp_grant[1] = 32'd2; exp_grant[2] = 32'd1; exp_grant[3] = 32'd2;
`else
    exp_grant[0] = 32'd1; exp_grant[1] = 32'd1; exp_grant[2] = 32'd1; exp_grant[3] = 32'd1;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_memen", me1, 0);
    check("rst_memwrite", mw1, 0);
    check("rst_adr", adr1, 0);
    check("rst_wdata", wd1, 0);
    check("rst_c_ready", c1.ready, 0);
    check("rst_c_rdata", c1.rdata, 0);
    check("rst_l_rdata", l3.rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES=1 core write Adr=100 data=7
    c1.req = 1; c1.we = 1; c1.adr = 100; c1.wdata = 7;
    @(negedge clk);
    check("w1_memen", me1, 1);
    check("w1_memwrite", mw1, 1);
    check("w1_adr", adr1, 100);
    check("w1_wdata", wd1, 7);
    check("w1_ready_early", c1.ready, 0);
    @(negedge clk);
    check("w1_ready", c1.ready, 1);
    check("w1_l_ready", l1.ready, 0);
    check("w1_memwrite_after", mw1, 0);
    check("w1_memen_after", me1, 0);
    check("w1_adr_after", adr1, 0);
    check("w1_rdata_unchanged", c1.rdata, 0);
    c1.req = 0; c1.we = 0;
    @(negedge clk);
    check("w1_ready_single", c1.ready, 0);

    // WAIT_CYCLES=3 loader read Adr=0x20
    l3.req = 1; l3.we = 0; l3.adr = 32'h20; rd3 = 32'hE3A0_0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r3_memen", me3, 1);
      check("r3_adr", adr3, 32'h20);
      check("r3_memwrite", mw3, 0);
      check("r3_ready_early", l3.ready, 0);
    end
    @(negedge clk);
    check("r3_ready", l3.ready, 1);
    check("r3_rdata", l3.rdata, 32'hE3A0_0005);
    check("r3_c_ready", c3.ready, 0);
    check("r3_memen_after", me3, 0);
    l3.req = 0; rd3 = 32'h0BAD_0BAD;
    @(negedge clk);
    check("r3_ready_single", l3.ready, 0);
    check("r3_rdata_hold", l3.rdata, 32'hE3A0_0005);

    // WAIT_CYCLES=3 core write, address changed mid-transfer
    c3.req = 1; c3.we = 1; c3.adr = 100; c3.wdata = 32'h55;
    @(negedge clk);
    check("w3_adr_c1", adr3, 100);
    check("w3_mw_c1", mw3, 0);
    c3.adr = 200; c3.wdata = 32'h66;
    @(negedge clk);
    check("w3_adr_c2", adr3, 100);
    check("w3_wdata_c2", wd3, 32'h55);
    check("w3_mw_c2", mw3, 0);
    @(negedge clk);
    check("w3_adr_c3", adr3, 100);
    check("w3_mw_c3", mw3, 1);
    @(negedge clk);
    check("w3_ready", c3.ready, 1);
    check("w3_mw_done", mw3, 0);
    check("w3_adr_done", adr3, 0);
    check("w3_c_rdata_unchanged", c3.rdata, 0);
    check("w3_l_rdata_unchanged", l3.rdata, 32'hE3A0_0005);
    c3.req = 0; c3.we = 0;
    @(negedge clk);

    // Reset asserted in ACCESS of a write to Adr=100
    c3.req = 1; c3.we = 1; c3.adr = 100; c3.wdata = 9;
    @(negedge clk);
    check("ra_memen", me3, 1);
    check("ra_mw_pre", mw3, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("ra_memen_rst", me3, 0);
    check("ra_adr_rst", adr3, 0);
    check("ra_wdata_rst", wd3, 0);
    check("ra_mw_rst", mw3, 0);
    check("ra_l_rdata_rst", l3.rdata, 0);
    c3.req = 0; c3.we = 0;
    @(negedge clk);
    reset = 1'b0;
    seen_mw = 1'b0; seen_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_mw  = seen_mw | mw3;
      seen_rdy = seen_rdy | c3.ready;
    end
    check("ra_no_memwrite", seen_mw, 0);
    check("ra_no_ready", seen_rdy, 0);

    // Contention on WAIT_CYCLES=1: both requests held continuously
    rd1 = 32'hC0DE_0001;
    c1.req = 1; c1.we = 0; c1.adr = 1;
    l1.req = 1; l1.we = 0; l1.adr = 2;
    for (int t = 0; t < 4; t++) begin
      wait_memen1(found);
      check("ct_found", found, 1);
      check("ct_grant", adr1, exp_grant[t]);
      @(negedge clk);
      check("ct_c_ready", c1.ready, (exp_grant[t] == 32'd1) ? 32'd1 : 32'd0);
      check("ct_l_ready", l1.ready, (exp_grant[t] == 32'd2) ? 32'd1 : 32'd0);
      if (exp_grant[t] == 32'd1) check("ct_c_rdata", c1.rdata, 32'hC0DE_0001);
      else                       check("ct_l_rdata", l1.rdata, 32'hC0DE_0001);
    end
    // Core drops out; the waiting loader must still be served
    c1.req = 0;
    rd1 = 32'h0000_0A0A;
    wait_memen1(found);
    check("ld_found", found, 1);
    check("ld_grant", adr1, 2);
    @(negedge clk);
    check("ld_ready", l1.ready, 1);
    check("ld_c_ready", c1.ready, 0);
    check("ld_rdata", l1.rdata, 32'h0000_0A0A);
    l1.req = 0;
    @(negedge clk);
    check("end_l_ready", l1.ready, 0);
    check("end_memen", me1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
